// File: rtl/gray_ptr_sync_cmp_pkg.sv
// Shared pointer helpers for the async-FIFO pointer logic.
// Gray/binary conversions work on a wide word; callers zero-extend their
// pointer in and size-cast the result back, which is exact because the
// conversion of a zero-extended value leaves the upper bits at zero.
package gray_ptr_sync_cmp_pkg;

   // Which FIFO side an instance serves
   typedef enum logic [0:0] {
      SIDE_READ  = 1'b0,
      SIDE_WRITE = 1'b1
   } fifo_side_e;

   localparam int unsigned PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin = gray;
      for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // Binary to Gray: adjacent-bit XOR
   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_ptr_sync_cmp_if.sv
// Bundle between the local FIFO pointer logic and the pointer-compare block.
// master: the local counter / FIFO control; slave: gray_ptr_sync_cmp.
interface gray_ptr_sync_cmp_if #(
   parameter int unsigned WIDTH = 5
);

   logic [WIDTH-1:0] i_remote_gray;       // remote Gray pointer, registered in the remote domain
   logic [WIDTH-1:0] i_local_bin;         // local binary pointer, current value
   logic [WIDTH-1:0] i_local_bin_next;    // local binary pointer, next value
   logic [WIDTH-1:0] i_almost_thresh;     // almost threshold, 0..DEPTH, quasi-static
   logic [WIDTH-1:0] o_remote_gray_sync;  // last synchronizer stage
   logic [WIDTH-1:0] ow_remote_bin_sync;  // binary of the synchronized pointer (combinational)
   logic [WIDTH-1:0] o_count;             // registered occupancy
   logic             o_flag;              // registered empty (read) / full (write)
   logic             o_almost;            // registered almost-empty / almost-full

   modport master (
      output i_remote_gray,
      output i_local_bin,
      output i_local_bin_next,
      output i_almost_thresh,
      input  o_remote_gray_sync,
      input  ow_remote_bin_sync,
      input  o_count,
      input  o_flag,
      input  o_almost
   );

   modport slave (
      input  i_remote_gray,
      input  i_local_bin,
      input  i_local_bin_next,
      input  i_almost_thresh,
      output o_remote_gray_sync,
      output ow_remote_bin_sync,
      output o_count,
      output o_flag,
      output o_almost
   );

endinterface

// File: rtl/gray_ptr_sync_cmp_chk.sv
// Simulation-only protocol checks for gray_ptr_sync_cmp: things the RTL
// relies on but does not enforce.
module gray_ptr_sync_cmp_chk
   import gray_ptr_sync_cmp_pkg::*;
#(
   parameter int unsigned WIDTH       = 5,
   parameter int unsigned SYNC_STAGES = 3
) (
   input logic             i_clk,
   input logic             i_rst_n,
   input logic [WIDTH-1:0] i_remote_gray,
   input logic [WIDTH-1:0] i_local_bin,
   input logic [WIDTH-1:0] i_local_bin_next,
   input logic [WIDTH-1:0] i_gray_sync,
   input logic [WIDTH-1:0] i_bin_sync,
   input logic [WIDTH-1:0] i_count_d
);

   localparam logic [WIDTH-1:0] DEPTH    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] STEP_MAX = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] local_step_s;

   assign local_step_s = i_local_bin_next - i_local_bin;

   if (WIDTH < 2) begin : g_bad_width
      $error("gray_ptr_sync_cmp: WIDTH must be at least 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("gray_ptr_sync_cmp: SYNC_STAGES must be at least 2");
   end

   // A Gray pointer may only move by one code per local cycle
   a_remote_gray_one_bit : assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(i_remote_gray ^ $past(i_remote_gray)));

   // The local counter advances by zero or one
   a_local_step : assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      local_step_s <= STEP_MAX);

   // Occupancy never exceeds the FIFO depth
   a_count_range : assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      i_count_d <= DEPTH);

   // Converted binary must map back to the synchronized Gray code
   a_conv_roundtrip : assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      WIDTH'(bin2gray(ptr_word_t'(i_bin_sync))) == i_gray_sync);

endmodule

// File: rtl/gray_ptr_sync_cmp_sync.sv
// sync_n_dff_arn: plain N-deep flop chain with async active-low reset.
// Meant for Gray-coded or otherwise single-bit-change buses crossing clock
// domains; nothing sits between stages so every stage gets a full cycle to
// resolve metastability.
module sync_n_dff_arn #(
   parameter int unsigned WIDTH  = 5,
   parameter int unsigned STAGES = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] stage_d;
   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   // Next chain state: first stage samples the input, others copy the previous stage
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = i_d;
      for (int s = 1; s < int'(STAGES); s++) begin
         stage_d[s] = stage_q[s-1];
      end
   end

   // Synchronizer flops, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign o_q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_cmp.sv
// gray_ptr_sync_cmp: async-FIFO pointer consumer.
// Brings the remote Gray pointer into the local domain, converts it to
// binary and compares it against the local *next* pointer, so the flags
// move on the same edge as the local pointer. The synchronizer only makes
// the remote pointer look older, so empty/full can clear late, never early.
module gray_ptr_sync_cmp
   import gray_ptr_sync_cmp_pkg::*;
#(
   parameter int unsigned WIDTH       = 5,
   parameter int unsigned SYNC_STAGES = 3,
   parameter bit          WRITE_SIDE  = 1'b0
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   gray_ptr_sync_cmp_if.slave  bus
);

   localparam fifo_side_e       SIDE     = (WRITE_SIDE != 1'b0) ? SIDE_WRITE : SIDE_READ;
   localparam logic [WIDTH-1:0] DEPTH    = {1'b1, {(WIDTH-1){1'b0}}};
   // Read side comes out of reset empty; write side comes out not full
   localparam logic             FLAG_RST = (SIDE == SIDE_READ) ? 1'b1 : 1'b0;

   logic [WIDTH-1:0] rem_gray_sync_s;
   logic [WIDTH-1:0] rem_bin_sync_s;
   logic [WIDTH-1:0] local_next_s;

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;
   logic             flag_d;
   logic             flag_q;
   logic             almost_d;
   logic             almost_q;

   sync_n_dff_arn #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (bus.i_remote_gray),
      .o_q     (rem_gray_sync_s)
   );

   // Binary view of the synchronized remote pointer
   always_comb begin
      rem_bin_sync_s = WIDTH'(gray2bin(ptr_word_t'(rem_gray_sync_s)));
   end

   // Occupancy and flag terms; all subtraction wraps modulo 2**WIDTH
   always_comb begin
      local_next_s = bus.i_local_bin_next;
      count_d      = '0;
      flag_d       = FLAG_RST;
      almost_d     = FLAG_RST;
      case (SIDE)
         SIDE_WRITE: begin
            // Same low bits but opposite wrap bit: writer is a full lap ahead
            count_d  = local_next_s - rem_bin_sync_s;
            flag_d   = (local_next_s[WIDTH-1] != rem_bin_sync_s[WIDTH-1]) &&
                       (local_next_s[WIDTH-2:0] == rem_bin_sync_s[WIDTH-2:0]);
            almost_d = (count_d >= (DEPTH - bus.i_almost_thresh));
         end
         SIDE_READ: begin
            count_d  = rem_bin_sync_s - local_next_s;
            flag_d   = (local_next_s == rem_bin_sync_s);
            almost_d = (count_d <= bus.i_almost_thresh);
         end
         default: begin
            count_d  = '0;
            flag_d   = FLAG_RST;
            almost_d = FLAG_RST;
         end
      endcase
   end

   // Output registers; reset drops to the side's idle state immediately
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q  <= '0;
         flag_q   <= FLAG_RST;
         almost_q <= FLAG_RST;
      end else begin
         count_q  <= count_d;
         flag_q   <= flag_d;
         almost_q <= almost_d;
      end
   end

   assign bus.o_remote_gray_sync = rem_gray_sync_s;
   assign bus.ow_remote_bin_sync = rem_bin_sync_s;
   assign bus.o_count            = count_q;
   assign bus.o_flag             = flag_q;
   assign bus.o_almost           = almost_q;

`ifndef SYNTHESIS
   gray_ptr_sync_cmp_chk #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_chk (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_remote_gray    (bus.i_remote_gray),
      .i_local_bin      (bus.i_local_bin),
      .i_local_bin_next (bus.i_local_bin_next),
      .i_gray_sync      (rem_gray_sync_s),
      .i_bin_sync       (rem_bin_sync_s),
      .i_count_d        (count_d)
   );
`endif

endmodule

// File: tb/tb_gray_ptr_sync_cmp.sv
// Bench for gray_ptr_sync_cmp: one read-side and one write-side instance on
// a shared clock/reset. The reference model keeps remote pointers as plain
// binary counters and a delay line of SYNC_STAGES edges, and derives count
// and flags from integer occupancy.
module tb_gray_ptr_sync_cmp;

   localparam int W     = 5;
   localparam int S     = 3;
   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   // Bench-side pointers (binary)
   logic [W-1:0] rd_rem, rd_loc, rd_nxt, rd_th;
   logic [W-1:0] wr_rem, wr_loc, wr_nxt, wr_th;

   // Reference model state
   logic [W-1:0] rd_dly [S];
   logic [W-1:0] wr_dly [S];
   logic [W-1:0] e_rd_cnt, e_rd_sync, e_wr_cnt, e_wr_sync;
   logic         e_rd_flag, e_rd_alm, e_wr_flag, e_wr_alm;

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   gray_ptr_sync_cmp_if #(.WIDTH(W)) rd_if ();
   gray_ptr_sync_cmp_if #(.WIDTH(W)) wr_if ();

   assign rd_if.i_remote_gray    = to_gray(rd_rem);
   assign rd_if.i_local_bin      = rd_loc;
   assign rd_if.i_local_bin_next = rd_nxt;
   assign rd_if.i_almost_thresh  = rd_th;
   assign wr_if.i_remote_gray    = to_gray(wr_rem);
   assign wr_if.i_local_bin      = wr_loc;
   assign wr_if.i_local_bin_next = wr_nxt;
   assign wr_if.i_almost_thresh  = wr_th;

   gray_ptr_sync_cmp #(.WIDTH(W), .SYNC_STAGES(S), .WRITE_SIDE(1'b0)) u_rd (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (rd_if.slave)
   );

   gray_ptr_sync_cmp #(.WIDTH(W), .SYNC_STAGES(S), .WRITE_SIDE(1'b1)) u_wr (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (wr_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < S; i++) begin
         rd_dly[i] = '0;
         wr_dly[i] = '0;
      end
      e_rd_cnt  = '0; e_rd_sync = '0; e_rd_flag = 1'b1; e_rd_alm = 1'b1;
      e_wr_cnt  = '0; e_wr_sync = '0; e_wr_flag = 1'b0; e_wr_alm = 1'b0;
   endtask

   // Model of one local clock edge: remote value seen locally is the one
   // present SYNC_STAGES edges earlier
   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         e_rd_cnt  = rd_dly[S-1] - rd_nxt;
         e_rd_flag = (e_rd_cnt == '0);
         e_rd_alm  = (int'(e_rd_cnt) <= int'(rd_th));
         e_wr_cnt  = wr_nxt - wr_dly[S-1];
         e_wr_flag = (int'(e_wr_cnt) == DEPTH);
         e_wr_alm  = (int'(e_wr_cnt) >= DEPTH - int'(wr_th));
         for (int i = S - 1; i > 0; i--) begin
            rd_dly[i] = rd_dly[i-1];
            wr_dly[i] = wr_dly[i-1];
         end
         rd_dly[0] = rd_rem;
         wr_dly[0] = wr_rem;
         e_rd_sync = rd_dly[S-1];
         e_wr_sync = wr_dly[S-1];
      end
   endtask

   task automatic check_all();
      check_eq("rd_count",  32'(rd_if.o_count),            32'(e_rd_cnt));
      check_eq("rd_empty",  32'(rd_if.o_flag),             32'(e_rd_flag));
      check_eq("rd_almost", 32'(rd_if.o_almost),           32'(e_rd_alm));
      check_eq("rd_gsync",  32'(rd_if.o_remote_gray_sync), 32'(to_gray(e_rd_sync)));
      check_eq("rd_bsync",  32'(rd_if.ow_remote_bin_sync), 32'(e_rd_sync));
      check_eq("wr_count",  32'(wr_if.o_count),            32'(e_wr_cnt));
      check_eq("wr_full",   32'(wr_if.o_flag),             32'(e_wr_flag));
      check_eq("wr_almost", 32'(wr_if.o_almost),           32'(e_wr_alm));
      check_eq("wr_gsync",  32'(wr_if.o_remote_gray_sync), 32'(to_gray(e_wr_sync)));
      check_eq("wr_bsync",  32'(wr_if.ow_remote_bin_sync), 32'(e_wr_sync));
   endtask

   // One local clock edge: model, sample 1 time unit later, local pointers follow next
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      rd_loc = rd_nxt;
      wr_loc = wr_nxt;
   endtask

   task automatic clear_ptrs();
      rd_rem = '0; rd_loc = '0; rd_nxt = '0; rd_th = 5'd4;
      wr_rem = '0; wr_loc = '0; wr_nxt = '0; wr_th = 5'd4;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_ptrs();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp2_cnt [6];
      int exp2_flg [6];
      int exp6_cnt [4];
      logic [W-1:0] occ;
      int pr, pc;

      exp2_cnt = '{0, 0, 0, 1, 2, 3};
      exp2_flg = '{1, 1, 1, 0, 0, 0};
      exp6_cnt = '{0, 0, 0, 7};
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      clear_ptrs();
      model_reset();

      // 1. reset values on both sides
      do_reset();
      check_eq("t1_rd_flag",   32'(rd_if.o_flag),   32'd1);
      check_eq("t1_rd_count",  32'(rd_if.o_count),  32'd0);
      check_eq("t1_rd_almost", 32'(rd_if.o_almost), 32'd1);
      check_eq("t1_wr_flag",   32'(wr_if.o_flag),   32'd0);
      check_eq("t1_wr_count",  32'(wr_if.o_count),  32'd0);
      check_eq("t1_wr_almost", 32'(wr_if.o_almost), 32'd0);

      // 2. remote Gray 0->1->3->2 on consecutive edges, N=0
      for (int k = 0; k < 6; k++) begin
         if (k < 3) rd_rem = W'(k + 1);
         tick();
         check_eq("t2_count", 32'(rd_if.o_count), 32'(exp2_cnt[k]));
         check_eq("t2_empty", 32'(rd_if.o_flag),  32'(exp2_flg[k]));
      end

      // 3. R=3 settled, N steps 1,2,3
      for (int k = 1; k <= 3; k++) begin
         rd_nxt = W'(k);
         tick();
         check_eq("t3_count", 32'(rd_if.o_count), 32'(3 - k));
         check_eq("t3_empty", 32'(rd_if.o_flag),  32'(k == 3));
      end

      // 4. write side wrap: N=16, R=0 is full; remote read of one entry clears it 4 edges later
      do_reset();
      for (int k = 0; k < 16; k++) begin
         wr_nxt = wr_loc + 1'b1;
         tick();
      end
      check_eq("t4_full",   32'(wr_if.o_flag),   32'd1);
      check_eq("t4_count",  32'(wr_if.o_count),  32'd16);
      check_eq("t4_almost", 32'(wr_if.o_almost), 32'd1);
      wr_rem = 5'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("t4_full_hold", 32'(wr_if.o_flag), 32'd1);
      end
      tick();
      check_eq("t4_full_clr",  32'(wr_if.o_flag),  32'd0);
      check_eq("t4_count_clr", 32'(wr_if.o_count), 32'd15);

      // 5. almost-empty around threshold 4, then threshold 0
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         rd_rem = W'(k);
         tick();
      end
      repeat (4) tick();
      check_eq("t5_almost_c3", 32'(rd_if.o_almost), 32'd1);
      rd_rem = 5'd4;
      repeat (4) tick();
      check_eq("t5_almost_c4", 32'(rd_if.o_almost), 32'd1);
      check_eq("t5_count_c4",  32'(rd_if.o_count),  32'd4);
      rd_rem = 5'd5;
      repeat (3) tick();
      check_eq("t5_almost_lag", 32'(rd_if.o_almost), 32'd1);
      tick();
      check_eq("t5_almost_c5", 32'(rd_if.o_almost), 32'd0);
      rd_th = 5'd0;
      repeat (2) tick();
      check_eq("t5_almost_th0", 32'(rd_if.o_almost), 32'd0);

      // 6. async reset mid-cycle with count 7
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         rd_rem = W'(k);
         tick();
      end
      repeat (4) tick();
      check_eq("t6_count_pre", 32'(rd_if.o_count), 32'd7);
      #3;
      rst_n  = 1'b0;
      rd_loc = '0; rd_nxt = '0;
      wr_rem = '0; wr_loc = '0; wr_nxt = '0;
      model_reset();
      #2;
      check_eq("t6_rst_count",  32'(rd_if.o_count),            32'd0);
      check_eq("t6_rst_empty",  32'(rd_if.o_flag),             32'd1);
      check_eq("t6_rst_almost", 32'(rd_if.o_almost),           32'd1);
      check_eq("t6_rst_gsync",  32'(rd_if.o_remote_gray_sync), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("t6_count_post", 32'(rd_if.o_count), 32'(exp6_cnt[k]));
      end

      // Randomized traffic on both sides, in phases that fill, drain, mix and burst
      do_reset();
      for (int c = 0; c < 800; c++) begin
         case (c / 200)
            0:       begin pr = 85; pc = 15; end
            1:       begin pr = 15; pc = 85; end
            2:       begin pr = 50; pc = 50; end
            default: begin pr = 90; pc = 90; end
         endcase
         if (c % 50 == 0) begin
            rd_th = W'($urandom_range(0, DEPTH));
            wr_th = W'($urandom_range(0, DEPTH));
         end
         // read side: remote writer never gets more than DEPTH ahead of the local reader
         occ = rd_rem - rd_loc;
         if (int'($urandom_range(0, 99)) < pr && int'(occ) < DEPTH) rd_rem = rd_rem + 1'b1;
         if (int'($urandom_range(0, 99)) < pc && rd_loc != rd_dly[S-1]) rd_nxt = rd_loc + 1'b1;
         else rd_nxt = rd_loc;
         // write side: local writer stops when the synchronized view is full
         occ = wr_loc - wr_dly[S-1];
         if (int'($urandom_range(0, 99)) < pr && int'(occ) < DEPTH) wr_nxt = wr_loc + 1'b1;
         else wr_nxt = wr_loc;
         if (int'($urandom_range(0, 99)) < pc && wr_rem != wr_loc) wr_rem = wr_rem + 1'b1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
